// File: rtl/alu_pkg.sv
// Shared types for the t16q execution unit: op codes, flag layout and flag bit positions.
package alu_pkg;

  typedef enum logic [2:0] {
    ADD  = 3'd0,
    SUB  = 3'd1,
    AND  = 3'd2,
    XOR  = 3'd3,
    SHR  = 3'd4,
    LDUI = 3'd5,
    MUL  = 3'd6
  } alu_op_e;

  typedef struct packed {
    logic z;
    logic c;
    logic n;
    logic v;
  } alu_flags_t;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle datapath and flag generation. SHR here is the zero-amount case (pass-through);
// MUL and the unused code 7 both yield zero, and the sequencer never writes MUL's result from here.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] s1,
  input  logic [WIDTH-1:0] s2,
  output logic [WIDTH-1:0] d,
  output alu_flags_t       flags
);

  localparam int HALF = WIDTH / 2;

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           carry;
  logic           ovf;

  assign sum  = {1'b0, s1} + {1'b0, s2};
  assign diff = {1'b0, s1} - {1'b0, s2};

  always_comb begin
    d     = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op)
      ADD: begin
        d     = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf   = ~(s1[WIDTH-1] ^ s2[WIDTH-1]) & (sum[WIDTH-1] ^ s1[WIDTH-1]);
      end
      SUB: begin
        d     = diff[WIDTH-1:0];
        carry = diff[WIDTH];
        ovf   = (s1[WIDTH-1] ^ s2[WIDTH-1]) & (diff[WIDTH-1] ^ s1[WIDTH-1]);
      end
      AND:     d = s1 & s2;
      XOR:     d = s1 ^ s2;
      SHR:     d = s1;
      LDUI:    d = {s2[HALF-1:0], s1[HALF-1:0]};
      default: d = '0;
    endcase
    flags.z = (d == '0);
    flags.c = carry;
    flags.n = d[WIDTH-1];
    flags.v = ovf;
  end

endmodule

// File: rtl/alu_seq.sv
// Sequenced execution unit: valid/ready front end, iterative shifter and shift-add multiplier,
// and a held output register.
//
//   state   | meaning
//   S_IDLE  | accepting; single-cycle ops complete straight into the output register
//   S_SHIFT | moving one bit per cycle, cnt counts remaining steps
//   S_MUL   | one shift-add step per cycle over s2, LSB first, cnt counts remaining steps
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] s1,
  input  logic [WIDTH-1:0] s2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output alu_flags_t       flags
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_MUL   = 2'd2
  } state_e;

  state_e               state;
  logic [SHAMT_W-1:0]   cnt;
  logic [WIDTH-1:0]     work;
  logic                 shift_left;
  logic                 sticky;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     mcand;

  logic [WIDTH-1:0]     comb_d;
  alu_flags_t           comb_flags;
  logic [WIDTH-1:0]     shamt_mag;
  logic [SHAMT_W-1:0]   shamt;
  logic [WIDTH-1:0]     work_next;
  logic                 out_bit;
  logic                 sticky_next;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   prod_next;
  logic                 last_iter;
  logic                 accept;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .op    (op),
    .s1    (s1),
    .s2    (s2),
    .d     (comb_d),
    .flags (comb_flags)
  );

  assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Negative s2 means shift left by its magnitude; anything past WIDTH is equivalent to WIDTH.
  assign shamt_mag = s2[WIDTH-1] ? -s2 : s2;
  assign shamt     = (shamt_mag >= WIDTH'(WIDTH)) ? SHAMT_W'(WIDTH) : shamt_mag[SHAMT_W-1:0];

  assign work_next   = shift_left ? {work[WIDTH-2:0], 1'b0} : {1'b0, work[WIDTH-1:1]};
  assign out_bit     = shift_left ? work[WIDTH-1] : work[0];
  assign sticky_next = sticky | out_bit;

  // High half accumulates, low half holds the unconsumed multiplier bits.
  assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
  assign prod_next = {mul_sum, prod[WIDTH-1:1]};

  assign last_iter = (cnt == SHAMT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      out_valid  <= 1'b0;
      d          <= '0;
      flags      <= '0;
      cnt        <= '0;
      work       <= '0;
      shift_left <= 1'b0;
      sticky     <= 1'b0;
      prod       <= '0;
      mcand      <= '0;
    end else begin
      if (out_ready) out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (op == MUL) begin
              state <= S_MUL;
              prod  <= {{WIDTH{1'b0}}, s2};
              mcand <= s1;
              cnt   <= SHAMT_W'(WIDTH);
            end else if (op == SHR && shamt != '0) begin
              state      <= S_SHIFT;
              work       <= s1;
              shift_left <= s2[WIDTH-1];
              sticky     <= 1'b0;
              cnt        <= shamt;
            end else begin
              d         <= comb_d;
              flags     <= comb_flags;
              out_valid <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          work   <= work_next;
          sticky <= sticky_next;
          cnt    <= cnt - SHAMT_W'(1);
          if (last_iter) begin
            state     <= S_IDLE;
            d         <= work_next;
            flags.z   <= (work_next == '0);
            flags.c   <= sticky_next;
            flags.n   <= work_next[WIDTH-1];
            flags.v   <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        S_MUL: begin
          prod <= prod_next;
          cnt  <= cnt - SHAMT_W'(1);
          if (last_iter) begin
            state     <= S_IDLE;
            d         <= prod_next[WIDTH-1:0];
            flags.z   <= (prod_next[WIDTH-1:0] == '0);
            flags.c   <= |prod_next[2*WIDTH-1:WIDTH];
            flags.n   <= prod_next[WIDTH-1];
            flags.v   <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at WIDTH=16: directed, randomized, backpressure and reset cases
// against an arithmetic reference model.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  alu_op_e      op;
  logic [W-1:0] s1;
  logic [W-1:0] s2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] d;
  alu_flags_t   flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .s1        (s1),
    .s2        (s2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .flags     (flags)
  );

  // Reference: plain integer arithmetic; flags packed {z,c,n,v}; latency in cycles after accept.
  function automatic void model(input int code, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] ed, output logic [3:0] ef, output int elat);
    longint r;
    longint mask;
    logic   c;
    logic   v;
    int     k;
    int     sa;
    int     sb;
    int     ib;
    c    = 1'b0;
    v    = 1'b0;
    elat = 1;
    r    = 0;
    sa   = int'($signed(a));
    sb   = int'($signed(b));
    ib   = int'(b);
    case (code)
      0: begin
        r = longint'(a) + longint'(b);
        c = (r > 65535);
        v = (sa + sb > 32767) || (sa + sb < -32768);
      end
      1: begin
        r = longint'(a) - longint'(b);
        c = (a < b);
        v = (sa - sb > 32767) || (sa - sb < -32768);
      end
      2: r = longint'(a & b);
      3: r = longint'(a ^ b);
      4: begin
        if (ib < 32768) begin
          k    = (ib > 16) ? 16 : ib;
          mask = (longint'(1) << k) - 1;
          c    = ((longint'(a) & mask) != 0);
          r    = longint'(a) >> k;
        end else begin
          k = 65536 - ib;
          if (k > 16) k = 16;
          r = longint'(a) << k;
          c = ((r >> 16) != 0);
        end
        elat = (k == 0) ? 1 : k + 1;
      end
      5: r = longint'({b[7:0], a[7:0]});
      6: begin
        r    = longint'(a) * longint'(b);
        c    = ((r >> 16) != 0);
        elat = 17;
      end
      default: r = 0;
    endcase
    ed = r[15:0];
    ef = {(ed == 16'd0), c, ed[15], v};
  endfunction

  // Offers one op (waiting for in_ready), then observes the result; lat=-1 if it never appears.
  task automatic do_op(input int code, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] od, output logic [3:0] of, output int lat,
                       output int rdy_low);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b1;
    op       = alu_op_e'(3'(code));
    s1       = a;
    s2       = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op       = alu_op_e'(3'($urandom_range(0, 7)));
    s1       = 16'($urandom);
    s2       = 16'($urandom);
    lat      = 1;
    rdy_low  = 0;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      if (!in_ready) rdy_low++;
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
    od = d;
    of = flags;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold_valid: got %b expected 0", out_valid);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    checks++;
    if (d !== 16'h0000 || flags !== 4'b0000 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got d=%h flags=%b valid=%b expected 0000/0000/0", d, flags, out_valid);
    end
  endtask

  typedef struct {
    int          code;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] ed;
    logic [3:0]  ef;
    int          elat;
  } dir_t;

  task automatic test_directed();
    dir_t        tbl[14];
    logic [15:0] od;
    logic [3:0]  of;
    int          lat;
    int          rl;
    tbl[0]  = '{0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0011, 1};
    tbl[1]  = '{1, 16'h0000, 16'h0001, 16'hFFFF, 4'b0110, 1};
    tbl[2]  = '{5, 16'h1234, 16'h56AB, 16'hAB34, 4'b0010, 1};
    tbl[3]  = '{4, 16'h8001, 16'h0004, 16'h0800, 4'b0100, 5};
    tbl[4]  = '{4, 16'h8001, 16'h0014, 16'h0000, 4'b1100, 17};
    tbl[5]  = '{4, 16'hE001, 16'hFFFD, 16'h0008, 4'b0100, 4};
    tbl[6]  = '{4, 16'h1234, 16'h0000, 16'h1234, 4'b0000, 1};
    tbl[7]  = '{6, 16'h0100, 16'h0101, 16'h0100, 4'b0100, 17};
    tbl[8]  = '{6, 16'h00FF, 16'h0002, 16'h01FE, 4'b0000, 17};
    tbl[9]  = '{7, 16'h5555, 16'hAAAA, 16'h0000, 4'b1000, 1};
    tbl[10] = '{2, 16'hF0F0, 16'h0F0F, 16'h0000, 4'b1000, 1};
    tbl[11] = '{3, 16'hFFFF, 16'h0001, 16'hFFFE, 4'b0010, 1};
    tbl[12] = '{4, 16'h0001, 16'hFFF0, 16'h0000, 4'b1100, 17};
    tbl[13] = '{4, 16'h00FF, 16'h8000, 16'h0000, 4'b1100, 17};
    for (int i = 0; i < 14; i++) begin
      do_op(tbl[i].code, tbl[i].a, tbl[i].b, od, of, lat, rl);
      checks++;
      if (od !== tbl[i].ed || of !== tbl[i].ef) begin
        errors++;
        $display("FAIL directed_%0d result: got d=%h flags=%b expected d=%h flags=%b",
                 i, od, of, tbl[i].ed, tbl[i].ef);
      end
      checks++;
      if (lat !== tbl[i].elat) begin
        errors++;
        $display("FAIL directed_%0d latency: got %0d expected %0d", i, lat, tbl[i].elat);
      end
      if (tbl[i].elat > 1) begin
        checks++;
        if (rl !== tbl[i].elat - 1) begin
          errors++;
          $display("FAIL directed_%0d busy_cycles: got %0d expected %0d", i, rl, tbl[i].elat - 1);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] od;
    logic [15:0] ed;
    logic [3:0]  of;
    logic [3:0]  ef;
    int          code;
    int          lat;
    int          elat;
    int          rl;
    for (int i = 0; i < 60; i++) begin
      code = int'($urandom_range(0, 7));
      a    = 16'($urandom);
      b    = 16'($urandom);
      if (code == 4) begin
        case ($urandom_range(0, 3))
          0:       b = 16'($urandom);
          1:       b = 16'($urandom_range(0, 17));
          2:       b = 16'(65536 - int'($urandom_range(1, 17)));
          default: b = 16'h0000;
        endcase
      end
      model(code, a, b, ed, ef, elat);
      do_op(code, a, b, od, of, lat, rl);
      checks++;
      if (od !== ed || of !== ef || lat !== elat) begin
        errors++;
        $display("FAIL random_%0d op=%0d a=%h b=%h: got d=%h flags=%b lat=%0d expected d=%h flags=%b lat=%0d",
                 i, code, a, b, od, of, lat, ed, ef, elat);
      end
    end
  endtask

  task automatic test_back_to_back();
    int          sc_codes[6];
    int          code;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] ed;
    logic [15:0] prev_d;
    logic [3:0]  ef;
    logic [3:0]  prev_f;
    int          elat;
    sc_codes = '{0, 1, 2, 3, 5, 7};
    prev_d   = '0;
    prev_f   = '0;
    out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        checks++;
        if (out_valid !== 1'b1 || d !== prev_d || flags !== prev_f) begin
          errors++;
          $display("FAIL back_to_back_%0d: got valid=%b d=%h flags=%b expected valid=1 d=%h flags=%b",
                   i, out_valid, d, flags, prev_d, prev_f);
        end
      end
      if (i < 8) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL back_to_back_ready_%0d: got %b expected 1", i, in_ready);
        end
        code     = sc_codes[$urandom_range(0, 5)];
        a        = 16'($urandom);
        b        = 16'($urandom);
        model(code, a, b, ed, ef, elat);
        prev_d   = ed;
        prev_f   = ef;
        in_valid = 1'b1;
        op       = alu_op_e'(3'(code));
        s1       = a;
        s2       = b;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] ed;
    logic [15:0] xd;
    logic [3:0]  ef;
    logic [3:0]  xf;
    int          elat;
    @(negedge clk);
    model(0, 16'h4000, 16'h4000, ed, ef, elat);
    model(3, 16'hA5A5, 16'h0FF0, xd, xf, elat);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op        = ADD;
    s1        = 16'h4000;
    s2        = 16'h4000;
    @(posedge clk);
    #1;
    op = XOR;
    s1 = 16'hA5A5;
    s2 = 16'h0FF0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || d !== ed || flags !== ef || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold_%0d: got valid=%b d=%h flags=%b ready=%b expected 1/%h/%b/0",
                 i, out_valid, d, flags, in_ready, ed, ef);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release_ready: got %b expected 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || d !== xd || flags !== xf) begin
      errors++;
      $display("FAIL backpressure_no_bubble: got valid=%b d=%h flags=%b expected 1/%h/%b",
               out_valid, d, flags, xd, xf);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_drain: got valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_mul();
    logic [15:0] od;
    logic [3:0]  of;
    int          lat;
    int          rl;
    int          stale;
    do_op(0, 16'h0001, 16'h0001, od, of, lat, rl);
    in_valid = 1'b1;
    op       = MUL;
    s1       = 16'h1234;
    s2       = 16'h5678;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (d !== 16'h0002 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mul_midway: got d=%h ready=%b expected d=0002 ready=0", d, in_ready);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (d !== 16'h0000 || flags !== 4'b0000 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_mul_outputs: got d=%h flags=%b valid=%b expected 0000/0000/0",
               d, flags, out_valid);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_mul_ready: got %b expected 1", in_ready);
    end
    stale = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    checks++;
    if (stale !== 0) begin
      errors++;
      $display("FAIL reset_mid_mul_stale: got %0d valid cycles expected 0", stale);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = ADD;
    s1        = '0;
    s2        = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_mul();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
